display_scanner: RTL and testbench



---
 rtl/display_scanner_pkg.sv | 17 +
 rtl/display_scanner_if.sv | 12 +
 rtl/display_scanner_bin2bcd.sv | 94 +++++++++
 rtl/display_scanner.sv | 144 ++++++++++++++
 tb/tb_display_scanner.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/display_scanner_pkg.sv
// Shared definitions for the seven-segment display scanner: nibble width,
// converter state encoding and sizing of the BCD shift register.
package display_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } conv_state_e;

  // ceil(bin_w * log10(2)); the constant is rounded up so the count never comes out short
  function automatic int bcd_digits(input int bin_w);
    return (bin_w * 32'sd30103 + 32'sd99999) / 32'sd100000;
  endfunction

endpackage

// File: rtl/display_scanner_if.sv
// Value handshake into the display scanner: the producer is the master,
// the scanner's converter is the slave.
interface display_scanner_if #(
  parameter int BIN_W = 14
);
  logic             in_valid;
  logic [BIN_W-1:0] in_value;
  logic             in_ready;

  modport master (output in_valid, output in_value, input in_ready);
  modport slave  (input in_valid, input in_value, output in_ready);
endinterface

// File: rtl/display_scanner_bin2bcd.sv
// Sequential binary-to-BCD converter (shift-add-3). Accepts a value in IDLE,
// runs BIN_W shift cycles and pulses done_o alongside the final BCD vector.
module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int BIN_W = 14,
  parameter int NDIG  = bcd_digits(BIN_W)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  display_scanner_if.slave      in_if,
  output logic                  done_o,
  output logic [NDIG*BCD_W-1:0] bcd_o
);

  localparam int CNT_W  = $clog2(BIN_W + 1);
  localparam int BCD_TW = NDIG * BCD_W;
  localparam int SR_W   = BCD_TW + BIN_W;

  conv_state_e       state_q, state_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic [BCD_TW-1:0] bcd_q, bcd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BCD_TW-1:0] adj_s;
  logic [SR_W-1:0]   shl_s;

  // add-3 correction on every nibble, then one-bit left shift of {bcd, bin}
  always_comb begin
    adj_s = bcd_q;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_q[i*BCD_W +: BCD_W] >= 4'd5) begin
        adj_s[i*BCD_W +: BCD_W] = bcd_q[i*BCD_W +: BCD_W] + 4'd3;
      end else begin
        adj_s[i*BCD_W +: BCD_W] = bcd_q[i*BCD_W +: BCD_W];
      end
    end
    shl_s = {adj_s, bin_q} << 1'b1;
  end

  // converter FSM: accept in IDLE, BIN_W shifts in CONV, done on the last one
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    done_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_if.in_valid) begin
          bin_d   = in_if.in_value;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = CONV;
        end else begin
          state_d = IDLE;
        end
      end
      CONV: begin
        bin_d = shl_s[BIN_W-1:0];
        bcd_d = shl_s[SR_W-1:BIN_W];
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          done_o  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = CONV;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // converter state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bcd_o          = shl_s[SR_W-1:BIN_W];
  assign in_if.in_ready = (state_q == IDLE);

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed 7-segment scanner: converts an accepted value to BCD, clamps
// overflow to all nines and scans digits. DISPLAY_BLANK_EN enables leading-zero blanking.
module display_scanner
  import display_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int BIN_W       = 14,
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  display_scanner_if.slave  in_if,
  output logic [BCD_W-1:0]  bcd,
  output logic [DIGITS-1:0] an,
  output logic              ovf
);

  localparam int NDIG   = bcd_digits(BIN_W);
  localparam int WDIG   = (NDIG > DIGITS) ? NDIG : DIGITS;
  localparam int WIDE_W = WDIG * BCD_W;
  localparam int RC_W   = $clog2(REFRESH_DIV);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic                   conv_done_s;
  logic [NDIG*BCD_W-1:0]  conv_bcd_s;
  logic [WIDE_W-1:0]      wide_bcd_s;
  logic                   ovf_chk_s;
  logic                   wrap_s;
  logic [DIGITS-1:0]      lit_s;

  logic [BCD_W-1:0]       disp_q [DIGITS];
  logic [BCD_W-1:0]       disp_d [DIGITS];
  logic                   ovf_q, ovf_d;
  logic [RC_W-1:0]        rc_q, rc_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   scan_on_q, scan_on_d;
  logic [BCD_W-1:0]       bcd_q, bcd_d;
  logic [DIGITS-1:0]      an_q, an_d;
`ifdef DISPLAY_BLANK_EN
  logic                   upper_nz_s;
`endif

  bin2bcd_seq #(
    .BIN_W (BIN_W),
    .NDIG  (NDIG)
  ) u_conv (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_if  (in_if),
    .done_o (conv_done_s),
    .bcd_o  (conv_bcd_s)
  );

  assign wide_bcd_s = WIDE_W'(conv_bcd_s);

  // overflow clamp and atomic display update at the end of a conversion
  always_comb begin
    ovf_chk_s = 1'b0;
    for (int i = DIGITS; i < WDIG; i++) begin
      ovf_chk_s = ovf_chk_s | (wide_bcd_s[i*BCD_W +: BCD_W] != 4'd0);
    end
    disp_d = disp_q;
    ovf_d  = ovf_q;
    if (conv_done_s) begin
      for (int i = 0; i < DIGITS; i++) begin
        disp_d[i] = ovf_chk_s ? 4'd9 : wide_bcd_s[i*BCD_W +: BCD_W];
      end
      ovf_d = ovf_chk_s;
    end else begin
      disp_d = disp_q;
      ovf_d  = ovf_q;
    end
  end

  // refresh counter and digit index; anodes stay dark until the first wrap
  always_comb begin
    wrap_s    = (rc_q == RC_W'(REFRESH_DIV - 1));
    rc_d      = rc_q;
    idx_d     = idx_q;
    scan_on_d = scan_on_q;
    if (wrap_s) begin
      rc_d      = '0;
      scan_on_d = 1'b1;
      if (idx_q == IDX_W'(DIGITS - 1)) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      rc_d = rc_q + RC_W'(1);
    end
  end

  // which digits may light: all of them, or only up to the highest non-zero one
  always_comb begin
    lit_s = '1;
`ifdef DISPLAY_BLANK_EN
    upper_nz_s = 1'b0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      upper_nz_s = upper_nz_s | (disp_d[i] != 4'd0);
      lit_s[i]   = upper_nz_s;
    end
`endif
  end

  // next output values, taken from the post-edge index and display contents
  always_comb begin
    an_d  = '1;
    bcd_d = disp_d[idx_d];
    if (scan_on_d && lit_s[idx_d]) begin
      an_d[idx_d] = 1'b0;
    end else begin
      an_d = '1;
    end
  end

  // display, scan and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIGITS; i++) begin
        disp_q[i] <= 4'd0;
      end
      ovf_q     <= 1'b0;
      rc_q      <= '0;
      idx_q     <= '0;
      scan_on_q <= 1'b0;
      bcd_q     <= 4'd0;
      an_q      <= '1;
    end else begin
      disp_q    <= disp_d;
      ovf_q     <= ovf_d;
      rc_q      <= rc_d;
      idx_q     <= idx_d;
      scan_on_q <= scan_on_d;
      bcd_q     <= bcd_d;
      an_q      <= an_d;
    end
  end

  assign bcd = bcd_q;
  assign an  = an_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench for display_scanner: a decimal-arithmetic reference model
// predicts anodes, BCD digit, ready and overflow after every clock edge.
module tb_display_scanner;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;
  localparam int RD     = 4;
`ifdef DISPLAY_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [3:0]        bcd;
  logic [DIGITS-1:0] an;
  logic              ovf;

  display_scanner_if #(.BIN_W(BIN_W)) dif ();

  display_scanner #(
    .DIGITS      (DIGITS),
    .BIN_W       (BIN_W),
    .REFRESH_DIV (RD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in_if (dif),
    .bcd   (bcd),
    .an    (an),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state: edges since reset, pending conversion, shown value
  int m_cyc;
  bit m_conv;
  int m_done;
  int m_pend;
  int m_val;
  bit m_ovf;

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic int exp_digit(input int i);
    if (m_ovf) return 9;
    return (m_val / pow10(i)) % 10;
  endfunction

  function automatic bit exp_lit(input int i);
    if (!BLANK || i == 0 || m_ovf) return 1'b1;
    return m_val >= pow10(i);
  endfunction

  function automatic logic [DIGITS-1:0] exp_an();
    logic [DIGITS-1:0] a;
    int k;
    a = '1;
    k = (m_cyc / RD) % DIGITS;
    if (m_cyc >= RD && exp_lit(k)) a[k] = 1'b0;
    return a;
  endfunction

  function automatic logic [3:0] exp_bcd();
    return 4'(exp_digit((m_cyc / RD) % DIGITS));
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst_n) begin
      m_cyc++;
      if (m_conv) begin
        if (m_cyc == m_done) begin
          m_conv = 1'b0;
          m_ovf  = (m_pend > pow10(DIGITS) - 1);
          m_val  = m_pend;
        end
      end else if (dif.in_valid) begin
        m_conv = 1'b1;
        m_pend = int'(dif.in_value);
        m_done = m_cyc + BIN_W;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    dif.in_valid = 1'b0;
    dif.in_value = '0;
    repeat (3) @(negedge clk);
    m_cyc  = 0;
    m_conv = 1'b0;
    m_done = 0;
    m_pend = 0;
    m_val  = 0;
    m_ovf  = 1'b0;
    rst_n  = 1'b1;
  endtask

  task automatic accept(input int v);
    dif.in_valid = 1'b1;
    dif.in_value = BIN_W'(v);
    step();
    dif.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({an, bcd, dif.in_ready, ovf} !== {4'b1111, 4'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: an=%b bcd=%0d rdy=%b ovf=%b, expected 1111 0 1 0", an, bcd, dif.in_ready, ovf);
    end
    for (int c = 0; c < 20; c++) begin
      step();
      checks++;
      if ({an, bcd, dif.in_ready} !== {exp_an(), 4'd0, 1'b1}) begin
        errors++;
        $display("FAIL idle_scan cyc %0d: an=%b bcd=%0d rdy=%b, expected an=%b bcd=0 rdy=1", m_cyc, an, bcd, dif.in_ready, exp_an());
      end
    end
  endtask

  task automatic test_convert_1234();
    int low;
    logic [3:0] seen [DIGITS];
    logic [3:0] want [DIGITS];
    want = '{4'd4, 4'd3, 4'd2, 4'd1};
    for (int k = 0; k < DIGITS; k++) seen[k] = 4'hF;
    accept(1234);
    low = 0;
    for (int g = 0; g < 40; g++) begin
      if (dif.in_ready === 1'b1) break;
      low++;
      step();
    end
    checks++;
    if (low != BIN_W) begin
      errors++;
      $display("FAIL ready_low_len: got %0d cycles, expected %0d", low, BIN_W);
    end
    for (int c = 0; c < 4 * RD; c++) begin
      step();
      for (int k = 0; k < DIGITS; k++) if (an[k] === 1'b0) seen[k] = bcd;
      checks++;
      if ({an, bcd, ovf} !== {exp_an(), exp_bcd(), 1'b0}) begin
        errors++;
        $display("FAIL scan_1234 cyc %0d: an=%b bcd=%0d ovf=%b, expected an=%b bcd=%0d ovf=0", m_cyc, an, bcd, ovf, exp_an(), exp_bcd());
      end
    end
    for (int k = 0; k < DIGITS; k++) begin
      checks++;
      if (seen[k] !== want[k]) begin
        errors++;
        $display("FAIL digit_1234[%0d]: got %0d, expected %0d", k, seen[k], want[k]);
      end
    end
  endtask

  task automatic test_overflow();
    accept(12345);
    repeat (BIN_W) step();
    checks++;
    if ({ovf, dif.in_ready} !== 2'b11) begin
      errors++;
      $display("FAIL ovf_set: ovf=%b rdy=%b, expected ovf=1 rdy=1", ovf, dif.in_ready);
    end
    for (int c = 0; c < 4 * RD; c++) begin
      step();
      checks++;
      if (an !== exp_an() || (an !== 4'b1111 && bcd !== 4'd9)) begin
        errors++;
        $display("FAIL ovf_scan cyc %0d: an=%b bcd=%0d, expected an=%b bcd=9", m_cyc, an, bcd, exp_an());
      end
    end
    accept(7);
    repeat (BIN_W) step();
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: ovf=%b, expected 0", ovf);
    end
    for (int c = 0; c < 4 * RD; c++) begin
      step();
      checks++;
      if ({an, bcd} !== {exp_an(), exp_bcd()}) begin
        errors++;
        $display("FAIL scan_7 cyc %0d: an=%b bcd=%0d, expected an=%b bcd=%0d", m_cyc, an, bcd, exp_an(), exp_bcd());
      end
    end
  endtask

  task automatic test_blank_42();
    logic [DIGITS-1:0] low_seen;
    low_seen = '0;
    accept(42);
    repeat (BIN_W) step();
    for (int c = 0; c < 8 * RD; c++) begin
      step();
      low_seen = low_seen | ~an;
      checks++;
      if ({an, bcd} !== {exp_an(), exp_bcd()}) begin
        errors++;
        $display("FAIL scan_42 cyc %0d: an=%b bcd=%0d, expected an=%b bcd=%0d", m_cyc, an, bcd, exp_an(), exp_bcd());
      end
    end
    checks++;
    if (low_seen !== (BLANK ? 4'b0011 : 4'b1111)) begin
      errors++;
      $display("FAIL lit_set_42: got %b, expected %b", low_seen, BLANK ? 4'b0011 : 4'b1111);
    end
  endtask

  task automatic test_ignore_busy();
    logic [3:0] want [DIGITS];
    want = '{4'd0, 4'd0, 4'd0, 4'd1};
    accept(1000);
    repeat (3) step();
    dif.in_valid = 1'b1;
    dif.in_value = BIN_W'(555);
    step();
    dif.in_valid = 1'b0;
    repeat (BIN_W - 4) step();
    for (int c = 0; c < 4 * RD; c++) begin
      step();
      for (int k = 0; k < DIGITS; k++) begin
        if (an[k] === 1'b0) begin
          checks++;
          if (bcd !== want[k]) begin
            errors++;
            $display("FAIL ignore_555 digit %0d: got %0d, expected %0d", k, bcd, want[k]);
          end
        end
      end
      checks++;
      if ({an, dif.in_ready} !== {exp_an(), 1'b1}) begin
        errors++;
        $display("FAIL ignore_scan cyc %0d: an=%b rdy=%b, expected an=%b rdy=1", m_cyc, an, dif.in_ready, exp_an());
      end
    end
  endtask

  task automatic test_reset_mid_conv();
    accept(4321);
    repeat (5) step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({an, bcd, dif.in_ready, ovf} !== {4'b1111, 4'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: an=%b bcd=%0d rdy=%b ovf=%b, expected 1111 0 1 0", an, bcd, dif.in_ready, ovf);
    end
    do_reset();
    accept(9);
    for (int c = 0; c < BIN_W + 4 * RD; c++) begin
      step();
      if (an === 4'b1110) begin
        checks++;
        if (bcd !== 4'd9) begin
          errors++;
          $display("FAIL after_reset_9: bcd=%0d, expected 9", bcd);
        end
      end
      checks++;
      if ({an, bcd, dif.in_ready, ovf} !== {exp_an(), exp_bcd(), ~m_conv, m_ovf}) begin
        errors++;
        $display("FAIL post_reset cyc %0d: an=%b bcd=%0d rdy=%b ovf=%b, expected an=%b bcd=%0d rdy=%b ovf=%b",
                 m_cyc, an, bcd, dif.in_ready, ovf, exp_an(), exp_bcd(), ~m_conv, m_ovf);
      end
    end
  endtask

  task automatic test_random();
    int edge_vals [10];
    edge_vals = '{0, 9, 10, 99, 100, 999, 1000, 9999, 10000, 16383};
    for (int it = 0; it < 30; it++) begin
      int n;
      n = $urandom_range(0, 4) + BIN_W + 2 + $urandom_range(0, 12);
      dif.in_valid = 1'b1;
      dif.in_value = (it < 10) ? BIN_W'(edge_vals[it]) : BIN_W'($urandom_range(0, (1 << BIN_W) - 1));
      for (int c = 0; c < n; c++) begin
        step();
        checks++;
        if ({an, bcd, dif.in_ready, ovf} !== {exp_an(), exp_bcd(), ~m_conv, m_ovf}) begin
          errors++;
          $display("FAIL random it %0d cyc %0d: an=%b bcd=%0d rdy=%b ovf=%b, expected an=%b bcd=%0d rdy=%b ovf=%b",
                   it, m_cyc, an, bcd, dif.in_ready, ovf, exp_an(), exp_bcd(), ~m_conv, m_ovf);
        end
        dif.in_valid = ($urandom_range(0, 3) == 0) && (c < BIN_W);
        dif.in_value = BIN_W'($urandom_range(0, (1 << BIN_W) - 1));
      end
      dif.in_valid = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    dif.in_valid = 1'b1;
    for (int c = 0; c < 80; c++) begin
      dif.in_value = BIN_W'($urandom_range(0, 12000));
      step();
      checks++;
      if ({an, bcd, dif.in_ready, ovf} !== {exp_an(), exp_bcd(), ~m_conv, m_ovf}) begin
        errors++;
        $display("FAIL back_to_back cyc %0d: an=%b bcd=%0d rdy=%b ovf=%b, expected an=%b bcd=%0d rdy=%b ovf=%b",
                 m_cyc, an, bcd, dif.in_ready, ovf, exp_an(), exp_bcd(), ~m_conv, m_ovf);
      end
    end
    dif.in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_convert_1234();
    test_overflow();
    test_blank_42();
    test_ignore_busy();
    test_reset_mid_conv();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
